// File: rtl/freq_measure_pkg.sv
// Shared definitions for the frequency meter: counter width, default reference
// frequency and the saturating increment used by the edge counter.
package freq_measure_pkg;

    localparam int unsigned CNT_W               = 32;
    localparam int unsigned DEFAULT_REF_FREQ_HZ = 1_000_000;

    // Increment by one, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/freq_measure_sync.sv
// Input synchronizer plus rising-edge detector.
// Ports:
//   ref_freq  - reference clock
//   nReset    - asynchronous active-low reset
//   async_in  - signal asynchronous to ref_freq
//   rise      - one-cycle pulse per synchronized rising edge (decoded from flops)
module freq_measure_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic ref_freq,
    input  logic nReset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift the raw input in; prev holds the synchronized value one cycle late.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge ref_freq or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_measure.sv
// Frequency meter: counts rising edges of input_freq over a gate of GATE_CYCLES
// reference cycles and publishes the count once per gate.
// Ports:
//   ref_freq       - reference clock, the only clock
//   nReset         - asynchronous active-low reset
//   input_freq     - signal under measurement, asynchronous
//   measured_freq  - edge count of the last completed gate (held register)
module freq_measure
    import freq_measure_pkg::*;
#(
    parameter int unsigned REF_FREQ_HZ = DEFAULT_REF_FREQ_HZ,
    parameter int unsigned GATE_CYCLES = REF_FREQ_HZ,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             ref_freq,
    input  logic             nReset,
    input  logic             input_freq,
    output logic [CNT_W-1:0] measured_freq
);

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

    // Reject parameter sets the counting scheme cannot support.
    if (GATE_CYCLES < 2 || SYNC_STAGES < 2 || REF_FREQ_HZ == 0) begin : g_bad_params
        $error("freq_measure: GATE_CYCLES and SYNC_STAGES must be >= 2, REF_FREQ_HZ > 0");
    end

    logic             rise;
    logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] meas_q,     meas_d;

    freq_measure_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .ref_freq (ref_freq),
        .nReset   (nReset),
        .async_in (input_freq),
        .rise     (rise)
    );

    // Gate timing and counting; a rise in the terminal cycle belongs to the closing gate.
    always_comb begin
        gate_cnt_d = gate_cnt_q + CNT_W'(1);
        edge_cnt_d = rise ? sat_inc(edge_cnt_q) : edge_cnt_q;
        meas_d     = meas_q;
        if (gate_cnt_q == GATE_LAST) begin
            gate_cnt_d = '0;
            meas_d     = edge_cnt_d;
            edge_cnt_d = '0;
        end
    end

    always_ff @(posedge ref_freq or negedge nReset) begin
        if (!nReset) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            meas_q     <= '0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            meas_q     <= meas_d;
        end
    end

    assign measured_freq = meas_q;

endmodule

// File: tb/tb_freq_measure.sv
// Bench for freq_measure with a shortened gate: ref clock period 10 ns,
// gate = 1000 cycles = 10 us, so a square wave of period P ns reports ~10000/P.
module tb_freq_measure;

    localparam int unsigned G       = 1000;
    localparam int unsigned CLK_NS  = 10;
    localparam int unsigned GATE_NS = G * CLK_NS;
    localparam int unsigned NVEC    = 5;

    logic        clk;
    logic        rst_n;
    logic        fin;
    logic [31:0] measured;

    freq_measure #(
        .REF_FREQ_HZ (100_000_000),
        .GATE_CYCLES (G),
        .SYNC_STAGES (2)
    ) dut (
        .ref_freq      (clk),
        .nReset        (rst_n),
        .input_freq    (fin),
        .measured_freq (measured)
    );

    typedef struct {
        string       name;
        int unsigned period_ns;
        int unsigned exp_lo;
        int unsigned exp_hi;
    } vec_t;

    typedef struct {
        string       name;
        bit          chk;
        int unsigned lo;
        int unsigned hi;
    } sb_t;

    vec_t        vecs [NVEC];
    sb_t         exp_q [$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned period_ns = 0;
    int unsigned cyc;

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    // Square-wave source; period 0 holds the input low.
    initial begin
        fin = 1'b0;
        forever begin
            if (period_ns == 0) begin
                fin = 1'b0;
                #1;
            end else begin
                fin = 1'b1;
                #(period_ns / 2);
                fin = 1'b0;
                #(period_ns - period_ns / 2);
            end
        end
    end

    // Reference count of clock edges since reset release (gate boundaries at multiples of G).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic vec_t mk(string n, int unsigned p);
        vec_t v;
        int unsigned e;
        e           = (p == 0) ? 0 : GATE_NS / p;
        v.name      = n;
        v.period_ns = p;
        v.exp_lo    = (e == 0) ? 0 : e - 1;
        v.exp_hi    = (p == 0) ? 0 : e + 1;
        return v;
    endfunction

    task automatic check_range(string name, logic [31:0] act, int unsigned lo, int unsigned hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: measured_freq=%0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Output monitor: pops one scoreboard entry per gate boundary, checks hold mid-gate.
    initial begin : monitor
        sb_t e;
        bit  last_chk;
        int unsigned last_lo;
        int unsigned last_hi;
        last_chk = 1'b0;
        last_lo  = 0;
        last_hi  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                last_chk = 1'b0;
            end else begin
                if (cyc == G - 1)
                    check_range("no_early_update", measured, 0, 0);
                if (cyc != 0 && cyc % G == 0 && exp_q.size() != 0) begin
                    e        = exp_q.pop_front();
                    last_chk = e.chk;
                    last_lo  = e.lo;
                    last_hi  = e.hi;
                    if (e.chk) check_range(e.name, measured, e.lo, e.hi);
                end
                if (cyc > G && cyc % G == G / 2 && last_chk)
                    check_range("hold_mid_gate", measured, last_lo, last_hi);
            end
        end
    end

    initial begin : watchdog
        #(2_000_000);
        $display("FAIL timeout: simulation exceeded time limit, measured_freq=%0d", measured);
        $fatal(1, "timeout");
    end

    initial begin : main
        sb_t s;
        vecs[0] = mk("f_37ns",  37);
        vecs[1] = mk("f_23ns",  23);
        vecs[2] = mk("f_449ns", 449);
        vecs[3] = mk("f_zero",  0);
        vecs[4] = mk("f_131ns", 131);

        // Reset held with the input toggling.
        rst_n     = 1'b0;
        period_ns = vecs[0].period_ns;
        repeat (10) @(posedge clk);
        #1;
        check_range("reset_hold", measured, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Each frequency: the switching gate is a mix, the next full gate is checked.
        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) period_ns = vecs[i].period_ns;
            s = '{name: {vecs[i].name, "_switch"}, chk: 1'b0, lo: 0, hi: 0};
            exp_q.push_back(s);
            s = '{name: vecs[i].name, chk: 1'b1, lo: vecs[i].exp_lo, hi: vecs[i].exp_hi};
            exp_q.push_back(s);
            repeat (2 * G) @(posedge clk);
            #2;
        end

        // Reset mid-gate while measuring: immediate clear, then a clean gate from zero.
        period_ns = vecs[0].period_ns;
        s = '{name: "pre_reset_switch", chk: 1'b0, lo: 0, hi: 0};
        exp_q.push_back(s);
        repeat (G + G / 2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_range("async_reset_clear", measured, 0, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s = '{name: "after_reset_gate", chk: 1'b1, lo: vecs[0].exp_lo, hi: vecs[0].exp_hi};
        exp_q.push_back(s);
        repeat (G + 2) @(posedge clk);
        #2;

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
